// File: rtl/signal_conditioner_pkg.sv
// Shared types and default sizing for the multi-channel signal conditioner.
package signal_conditioner_pkg;
  typedef enum logic {ST_STABLE, ST_PENDING} sc_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;
endpackage

// File: rtl/sc_channel.sv
// One conditioner lane: synchroniser, stable-cycle counter, debounce FSM,
// registered edge pulses and a sticky glitch flag.
module sc_channel
  import signal_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] stable_cycles,
  input  logic             noisy_in,
  input  logic             glitch_clr,
  output logic             clean_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             glitch_flag
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       n_eff;
  logic [CNT_W:0]         cnt_inc;
  sc_state_e              state;
  logic                   sync;
  logic                   differs;
  logic                   commit;
  logic                   glitch_set;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign differs = sync != clean_out;
  // A zero threshold behaves like one so every change still costs a cycle.
  assign n_eff   = (stable_cycles == '0) ? CNT_W'(1) : stable_cycles;
  // One extra bit so cnt+1 cannot wrap before the compare.
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign commit  = cnt_inc >= {1'b0, n_eff};

  // A pending change abandoned by the input returning to the clean level.
  assign glitch_set = enable && !differs && (state == ST_PENDING);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      state       <= ST_STABLE;
      clean_out   <= RESET_VAL;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      glitch_flag <= 1'b0;
    end else begin
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      glitch_flag <= glitch_set | (glitch_flag & ~glitch_clr);
      if (!enable || !differs) begin
        cnt   <= '0;
        state <= ST_STABLE;
      end else if (commit) begin
        clean_out  <= sync;
        rise_pulse <= sync;
        fall_pulse <= ~sync;
        cnt        <= '0;
        state      <= ST_STABLE;
      end else begin
        cnt   <= cnt_inc[CNT_W-1:0];
        state <= ST_PENDING;
      end
    end
  end
endmodule

// File: rtl/signal_conditioner_mc.sv
// NUM_CH independent debounce lanes sharing enable and the stable-cycle threshold.
module signal_conditioner_mc
  import signal_conditioner_pkg::*;
#(
  parameter int   NUM_CH      = DEF_NUM_CH,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  stable_cycles,
  input  logic [NUM_CH-1:0] noisy_in,
  input  logic [NUM_CH-1:0] glitch_clr,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] glitch_flag
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sc_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RESET_VAL   (RESET_VAL)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .stable_cycles (stable_cycles),
      .noisy_in      (noisy_in[i]),
      .glitch_clr    (glitch_clr[i]),
      .clean_out     (clean_out[i]),
      .rise_pulse    (rise_pulse[i]),
      .fall_pulse    (fall_pulse[i]),
      .glitch_flag   (glitch_flag[i])
    );
  end
endmodule

// File: tb/tb_signal_conditioner_mc.sv
// Directed bench for signal_conditioner_mc: NUM_CH=4, SYNC_STAGES=2, threshold 5.
module tb_signal_conditioner_mc;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] stable_cycles;
  logic [3:0] noisy_in;
  logic [3:0] glitch_clr;
  logic [3:0] clean_out, rise_pulse, fall_pulse, glitch_flag;

  int n_checks = 0;
  int n_fail   = 0;

  signal_conditioner_mc #(
    .NUM_CH(4), .SYNC_STAGES(2), .CNT_W(8), .RESET_VAL(1'b0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .stable_cycles (stable_cycles),
    .noisy_in      (noisy_in),
    .glitch_clr    (glitch_clr),
    .clean_out     (clean_out),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .glitch_flag   (glitch_flag)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle; inputs written after this land before the next edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b1; stable_cycles = 8'd5;
    noisy_in = 4'h0; glitch_clr = 4'h0;
    #3;
    n_checks++;
    if ({clean_out, rise_pulse, fall_pulse, glitch_flag} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=0000", {clean_out, rise_pulse, fall_pulse, glitch_flag});
    end
    tick; tick;
    reset_n = 1'b1;
    repeat (3) tick;
  endtask

  task automatic test_clean_edge;
    noisy_in[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick;
      n_checks++;
      if ({clean_out, rise_pulse, fall_pulse, glitch_flag} !==
          {3'b000, k >= 7, 3'b000, k == 7, 4'h0, 4'h0}) begin
        n_fail++;
        $display("FAIL clean_rise k=%0d clean=%b rise=%b fall=%b glitch=%b exp clean=%b rise=%b",
                 k, clean_out, rise_pulse, fall_pulse, glitch_flag, {3'b000, k >= 7}, {3'b000, k == 7});
      end
    end
    repeat (11) tick;
    noisy_in[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick;
      n_checks++;
      if ({clean_out, rise_pulse, fall_pulse} !== {3'b000, k < 7, 4'h0, 3'b000, k == 7}) begin
        n_fail++;
        $display("FAIL clean_fall k=%0d clean=%b rise=%b fall=%b exp clean=%b fall=%b",
                 k, clean_out, rise_pulse, fall_pulse, {3'b000, k < 7}, {3'b000, k == 7});
      end
    end
  endtask

  task automatic test_glitch;
    noisy_in[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      noisy_in[1] = (k < 3);
      n_checks++;
      if (clean_out[1] !== 1'b0 || rise_pulse[1] !== 1'b0 || glitch_flag[1] !== (k >= 6)) begin
        n_fail++;
        $display("FAIL glitch_set k=%0d clean=%b rise=%b glitch=%b exp glitch=%b",
                 k, clean_out[1], rise_pulse[1], glitch_flag[1], k >= 6);
      end
    end
    glitch_clr[1] = 1'b1;
    tick;
    glitch_clr[1] = 1'b0;
    n_checks++;
    if (glitch_flag[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_clr got=%b exp=0", glitch_flag[1]);
    end
    // Hold clear across the edge where the glitch is detected.
    glitch_clr[1] = 1'b1;
    noisy_in[1]   = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick;
      noisy_in[1] = (k < 3);
      if (k == 6) begin
        glitch_clr[1] = 1'b0;
        n_checks++;
        if (glitch_flag[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL glitch_set_wins got=%b exp=1", glitch_flag[1]);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (glitch_flag[1] !== 1'b1 || clean_out[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch_sticky glitch=%b clean=%b exp 1/0", glitch_flag[1], clean_out[1]);
        end
      end
    end
    glitch_clr[1] = 1'b1;
    tick;
    glitch_clr[1] = 1'b0;
  endtask

  task automatic test_threshold;
    stable_cycles = 8'd0;
    noisy_in[2]   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick;
      if (k >= 2) begin
        n_checks++;
        if (clean_out[2] !== (k == 3) || rise_pulse[2] !== (k == 3)) begin
          n_fail++;
          $display("FAIL thr0_rise k=%0d clean=%b rise=%b exp=%b", k, clean_out[2], rise_pulse[2], k == 3);
        end
      end
    end
    stable_cycles = 8'd1;
    noisy_in[2]   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick;
      if (k >= 2) begin
        n_checks++;
        if (clean_out[2] !== (k == 2) || fall_pulse[2] !== (k == 3)) begin
          n_fail++;
          $display("FAIL thr1_fall k=%0d clean=%b fall=%b exp clean=%b fall=%b",
                   k, clean_out[2], fall_pulse[2], k == 2, k == 3);
        end
      end
    end
    stable_cycles = 8'd5;
    repeat (3) tick;
    // Exactly N synchronised cycles: accepted.
    noisy_in[3] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick;
      noisy_in[3] = (k < 5);
    end
    n_checks++;
    if (clean_out[3] !== 1'b1 || rise_pulse[3] !== 1'b1 || glitch_flag[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_exact5 clean=%b rise=%b glitch=%b exp 1/1/0", clean_out[3], rise_pulse[3], glitch_flag[3]);
    end
    repeat (8) tick;
    n_checks++;
    if (clean_out[3] !== 1'b0 || glitch_flag[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_exact5_return clean=%b glitch=%b exp 0/0", clean_out[3], glitch_flag[3]);
    end
    // N-1 synchronised cycles: rejected.
    noisy_in[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      noisy_in[3] = (k < 4);
    end
    n_checks++;
    if (clean_out[3] !== 1'b0 || glitch_flag[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL thr_short4 clean=%b glitch=%b exp 0/1", clean_out[3], glitch_flag[3]);
    end
    glitch_clr[3] = 1'b1;
    tick;
    glitch_clr[3] = 1'b0;
  endtask

  task automatic test_enable;
    logic seen;
    seen = 1'b0;
    noisy_in[0] = 1'b1;
    repeat (4) tick;
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      seen |= clean_out[0] | rise_pulse[0] | fall_pulse[0] | glitch_flag[0];
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_hold activity=%b exp=0", seen);
    end
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick;
      if (k >= 4) begin
        n_checks++;
        if (clean_out[0] !== (k == 5) || rise_pulse[0] !== (k == 5)) begin
          n_fail++;
          $display("FAIL enable_resume k=%0d clean=%b rise=%b exp=%b", k, clean_out[0], rise_pulse[0], k == 5);
        end
      end
    end
    stable_cycles = 8'd200;
    noisy_in[0]   = 1'b0;
    repeat (12) tick;
    n_checks++;
    if (clean_out[0] !== 1'b1 || fall_pulse[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_raised clean=%b fall=%b exp 1/0", clean_out[0], fall_pulse[0]);
    end
    stable_cycles = 8'd2;
    tick;
    n_checks++;
    if (clean_out[0] !== 1'b0 || fall_pulse[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL thr_lowered clean=%b fall=%b exp 0/1", clean_out[0], fall_pulse[0]);
    end
    stable_cycles = 8'd5;
    tick;
  endtask

  task automatic test_reset_pending;
    noisy_in[3] = 1'b1;
    repeat (8) tick;
    n_checks++;
    if (clean_out !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_pre clean=%b exp=1000", clean_out);
    end
    noisy_in[2] = 1'b1;
    repeat (5) tick;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({clean_out, rise_pulse, fall_pulse, glitch_flag} !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_async got=%h exp=0000", {clean_out, rise_pulse, fall_pulse, glitch_flag});
    end
    tick;
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick;
      if (k >= 6) begin
        n_checks++;
        if (clean_out !== (k == 7 ? 4'b1100 : 4'b0000) || rise_pulse !== (k == 7 ? 4'b1100 : 4'b0000) ||
            glitch_flag !== 4'b0000) begin
          n_fail++;
          $display("FAIL rst_recover k=%0d clean=%b rise=%b glitch=%b", k, clean_out, rise_pulse, glitch_flag);
        end
      end
    end
    noisy_in = 4'h0;
    repeat (9) tick;
  endtask

  task automatic test_parallel;
    int w [4];
    w = '{100, 3, 5, 4};
    glitch_clr = 4'hF;
    tick;
    glitch_clr = 4'h0;
    noisy_in   = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      tick;
      for (int i = 0; i < 4; i++) noisy_in[i] = (k < w[i]);
      if (k == 6) begin
        n_checks++;
        if (clean_out !== 4'b0000 || glitch_flag !== 4'b0010) begin
          n_fail++;
          $display("FAIL par_k6 clean=%b glitch=%b exp 0000/0010", clean_out, glitch_flag);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (clean_out !== 4'b0101 || rise_pulse !== 4'b0101 || glitch_flag !== 4'b1010) begin
          n_fail++;
          $display("FAIL par_k7 clean=%b rise=%b glitch=%b exp 0101/0101/1010", clean_out, rise_pulse, glitch_flag);
        end
      end
      if (k == 12) begin
        n_checks++;
        if (clean_out !== 4'b0001 || fall_pulse !== 4'b0100 || rise_pulse !== 4'b0000) begin
          n_fail++;
          $display("FAIL par_k12 clean=%b fall=%b rise=%b exp 0001/0100/0000", clean_out, fall_pulse, rise_pulse);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_clean_edge;
    test_glitch;
    test_threshold;
    test_enable;
    test_reset_pending;
    test_parallel;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/signal_conditioner_mc.md
# signal_conditioner_mc

Multi-channel, parametrised signal conditioner: synchronises NUM_CH asynchronous noisy inputs and debounces each one independently against a run-time stable-cycle threshold. Per channel it produces a clean level, one-cycle rise/fall pulses and a sticky glitch flag. It sits between raw board-level inputs (switches, external strobes) and synchronous control logic, and replaces the single-channel noisy_in/clean_out conditioner.

## Interface
Parameters:
- NUM_CH, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- CNT_W, 8, width of stable-cycle counter and threshold
- RESET_VAL, 1'b0, reset level of synchroniser flops and clean_out

Ports:
- clk  in  1  single clock; all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  global conditioning enable
- stable_cycles  in  CNT_W  debounce threshold N; effective N = max(stable_cycles, 1)
- noisy_in  in  NUM_CH  raw asynchronous inputs
- glitch_clr  in  NUM_CH  per-channel clear of glitch_flag
- clean_out  out  NUM_CH  debounced level
- rise_pulse  out  NUM_CH  one-cycle pulse on clean_out 0→1
- fall_pulse  out  NUM_CH  one-cycle pulse on clean_out 1→0
- glitch_flag  out  NUM_CH  sticky: a pending change was abandoned

## Operation
- Per channel: SYNC_STAGES-deep synchroniser → sync; counter cnt (CNT_W bits) → per-channel FSM.
- FSM states: ST_STABLE (cnt==0, sync==clean_out), ST_PENDING (cnt>0, sync differs).
- Each edge, enable=1:
  - sync==clean_out: cnt←0, state←ST_STABLE. If the previous state was ST_PENDING, glitch_flag←1.
  - sync!=clean_out, cnt+1 ≥ N: clean_out←sync, cnt←0, state←ST_STABLE. Assert rise_pulse or fall_pulse for exactly that one cycle.
  - otherwise: cnt←cnt+1, state←ST_PENDING.
- enable=0: synchronisers keep running; cnt forced to 0; clean_out held; no pulses; no glitch set. Comparison resumes on the first edge with enable=1.
- stable_cycles is read combinationally every cycle. If it is lowered below the current cnt+1, the change commits on the next edge. If raised, counting continues toward the new N.
- cnt never exceeds N-1, so it cannot wrap.
- glitch_flag clears when glitch_clr[i]=1. If set and clear occur in the same cycle, set wins.
- Rise and fall pulses are mutually exclusive per channel. Pulses are registered outputs, asserted in the same cycle clean_out shows its new value.

## Timing
- Reset (async assert, deasserted synchronously by the system): sync flops and clean_out = RESET_VAL; cnt=0; rise_pulse=fall_pulse=glitch_flag=0; state=ST_STABLE.
- Reset mid-pending: the pending change is discarded and no pulse is produced.
- Latency: noisy_in changes before edge 1 → sync changes at edge SYNC_STAGES → clean_out and pulse update at edge SYNC_STAGES+N. Total SYNC_STAGES+N cycles.
- Minimum accepted pulse width on noisy_in: N cycles after synchronisation. Shorter pulses set glitch_flag and leave clean_out unchanged.
- Channels are fully independent; no cross-channel ordering.

## Structure
- Package signal_conditioner_pkg holds:
  - typedef enum logic {ST_STABLE, ST_PENDING} sc_state_e
  - default parameter constants (NUM_CH, SYNC_STAGES, CNT_W)
- Sub-module sc_channel contains the synchroniser, counter, FSM, pulse and glitch logic for one channel. The top instantiates it NUM_CH times in a generate loop and shares enable and stable_cycles across channels.
- The interface gains NUM_CH-wide vectors plus enable, stable_cycles and glitch_clr. Driver clocking block outputs all inputs; the monitor samples all ports.

## Test plan
Bench configuration: NUM_CH=4, SYNC_STAGES=2, RESET_VAL=0, stable_cycles=5 unless noted.
- Clean edge: noisy_in[0] 0→1 held 20 cycles → clean_out[0]=1 at edge 7. rise_pulse[0] high for exactly that cycle; other channels unchanged.
- Glitch: noisy_in[1]=1 for 3 cycles then 0 → clean_out[1] stays 0; glitch_flag[1]=1 and stays set. glitch_clr[1] pulsed → flag 0 next edge. Set and clr in the same cycle → flag stays 1.
- Threshold boundary: stable_cycles=0 and 1 → both commit 3 cycles after the input change. Input pulse of exactly 5 synced cycles with stable_cycles=5 → accepted; 4 cycles → rejected with glitch.
- Enable/threshold change: enable=0 during a pending change → clean_out held, no pulse; commit N cycles after enable=1. stable_cycles lowered 200→2 while cnt=10 → commit next edge.
- Reset: reset_n low while channel 2 is pending with cnt=3 → all outputs 0 immediately; after release with noisy_in[2]=1 held → commit at edge 7.
- Parallel channels: all 4 channels toggled in the same cycle with differing pulse widths → independent correct clean/pulse/glitch results per channel.
